ysyx_23060191_imem_responder: RTL and testbench



---
 rtl/ysyx_23060191_imem_responder_if.sv | 25 ++
 rtl/ysyx_23060191_imem_responder.sv | 115 +++++++++++
 tb/tb_ysyx_23060191_imem_responder.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060191_imem_responder_if.sv
// Fetch request/response bundle between the IFU (master) and the instruction-memory responder (slave).
// Request: req_valid/req_ready/req_addr plus flush (jump redirect).
// Response: rsp_valid/rsp_ready/rsp_inst/rsp_err.
interface ysyx_23060191_imem_responder_if #(
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [DATA_W-1:0] req_addr;
    logic              flush;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_inst;
    logic              rsp_err;

    modport master (
        output req_valid, req_addr, flush, rsp_ready,
        input  req_ready, rsp_valid, rsp_inst, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, flush, rsp_ready,
        output req_ready, rsp_valid, rsp_inst, rsp_err
    );
endinterface

// File: rtl/ysyx_23060191_imem_responder.sv
// Purpose: word-addressed instruction array answering IFU fetches; flags misaligned/out-of-range fetches.
// Latency: rsp_valid is high LATENCY edges after the accepting edge (1..15); one fetch outstanding.
// Backpressure: response held stable until rsp_ready; req_ready only in IDLE; flush drops the fetch.
// Ports: clk/rstn (async active-low); bus = fetch handshake (slave side); ld_en/ld_idx/ld_data = preload
//        write port, usable in any state; resp_cnt = completed response handshakes (wraps at 16 bits).
module ysyx_23060191_imem_responder #(
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 1024,
    parameter logic [DATA_W-1:0] BASE_ADDR = DATA_W'(32'h8000_0000),
    parameter int                LATENCY   = 2
) (
    input  logic                       clk,
    input  logic                       rstn,
    ysyx_23060191_imem_responder_if.slave bus,
    input  logic                       ld_en,
    input  logic [$clog2(DEPTH)-1:0]   ld_idx,
    input  logic [DATA_W-1:0]          ld_data,
    output logic [15:0]                resp_cnt
);
    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]        r_state;
    logic [3:0]        r_cnt;
    logic [DATA_W-1:0] r_addr;
    logic [DATA_W-1:0] r_rsp_inst;
    logic              r_rsp_err;
    logic [15:0]       r_resp_cnt;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_accept;
    logic              w_sample;
    logic              w_hs;
    logic [DATA_W-1:0] w_samp_addr;
    logic [DATA_W-1:0] w_off;
    logic [DATA_W-1:0] w_word;
    logic [IDX_W-1:0]  w_idx;
    logic              w_fault;

    assign w_accept = bus.req_valid && (r_state == S_IDLE) && !bus.flush;

    // With LATENCY=1 the array is read on the accepting edge itself, straight from the bus.
    assign w_samp_addr = (r_state == S_IDLE) ? bus.req_addr : r_addr;
    assign w_off       = w_samp_addr - BASE_ADDR;
    assign w_word      = w_off >> 2;
    assign w_idx       = w_off[IDX_W+1:2];
    assign w_fault     = (w_samp_addr[1:0] != 2'b00) || (w_samp_addr < BASE_ADDR) ||
                         (w_word >= DATA_W'(DEPTH));

    assign w_sample = (w_accept && (LATENCY == 1)) ||
                      ((r_state == S_WAIT) && (r_cnt == 4'd1) && !bus.flush);
    // Flush wins over a simultaneous rsp_ready: the response is dropped, not counted.
    assign w_hs     = (r_state == S_RESP) && bus.rsp_ready && !bus.flush;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_addr     <= '0;
            r_rsp_inst <= '0;
            r_rsp_err  <= 1'b0;
            r_resp_cnt <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr  <= bus.req_addr;
                        r_cnt   <= 4'(LATENCY - 1);
                        r_state <= (LATENCY == 1) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.flush) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt == 4'd1) begin
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (bus.flush) begin
                        r_state <= S_IDLE;
                    end else if (w_hs) begin
                        r_state    <= S_IDLE;
                        r_resp_cnt <= r_resp_cnt + 16'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // Non-blocking read: a preload on this same edge is not yet visible (old data returned).
            if (w_sample) begin
                r_rsp_inst <= w_fault ? '0 : r_mem[w_idx];
                r_rsp_err  <= w_fault;
            end
        end
    end

    // Array is deliberately not reset so preloaded code survives a core reset.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            r_mem[ld_idx] <= ld_data;
        end
    end

    assign bus.req_ready = (r_state == S_IDLE);
    assign bus.rsp_valid = (r_state == S_RESP);
    assign bus.rsp_inst  = r_rsp_inst;
    assign bus.rsp_err   = r_rsp_err;
    assign resp_cnt      = r_resp_cnt;
endmodule

// File: tb/tb_ysyx_23060191_imem_responder.sv
// Directed bench for the instruction-memory responder: three instances (LATENCY 2, 1, 15) share the
// preload port; one is selected at a time for the fetch handshake. Outputs sampled on the falling edge,
// inputs driven on the falling edge or 1ns after the rising edge.
module tb_ysyx_23060191_imem_responder;
    logic        clk;
    logic        rstn;
    logic [1:0]  sel;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        flush;
    logic        rsp_ready;
    logic        ld_en;
    logic [9:0]  ld_idx;
    logic [31:0] ld_data;
    logic [15:0] cnt_a, cnt_b, cnt_c;

    logic        m_req_ready, m_rsp_valid, m_rsp_err;
    logic [31:0] m_rsp_inst;
    logic [15:0] m_resp_cnt;

    int n_cmp;
    int n_err;
    int exp_cnt;

    ysyx_23060191_imem_responder_if #(.DATA_W(32)) ifa ();
    ysyx_23060191_imem_responder_if #(.DATA_W(32)) ifb ();
    ysyx_23060191_imem_responder_if #(.DATA_W(32)) ifc ();

    assign ifa.req_valid = req_valid && (sel == 2'd0);
    assign ifb.req_valid = req_valid && (sel == 2'd1);
    assign ifc.req_valid = req_valid && (sel == 2'd2);
    assign ifa.flush     = flush && (sel == 2'd0);
    assign ifb.flush     = flush && (sel == 2'd1);
    assign ifc.flush     = flush && (sel == 2'd2);
    assign ifa.rsp_ready = rsp_ready;
    assign ifb.rsp_ready = rsp_ready;
    assign ifc.rsp_ready = rsp_ready;
    assign ifa.req_addr  = req_addr;
    assign ifb.req_addr  = req_addr;
    assign ifc.req_addr  = req_addr;

    ysyx_23060191_imem_responder #(.LATENCY(2)) dut_a (
        .clk(clk), .rstn(rstn), .bus(ifa),
        .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data), .resp_cnt(cnt_a)
    );
    ysyx_23060191_imem_responder #(.LATENCY(1)) dut_b (
        .clk(clk), .rstn(rstn), .bus(ifb),
        .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data), .resp_cnt(cnt_b)
    );
    ysyx_23060191_imem_responder #(.LATENCY(15)) dut_c (
        .clk(clk), .rstn(rstn), .bus(ifc),
        .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data), .resp_cnt(cnt_c)
    );

    always_comb begin
        m_req_ready = ifa.req_ready;
        m_rsp_valid = ifa.rsp_valid;
        m_rsp_inst  = ifa.rsp_inst;
        m_rsp_err   = ifa.rsp_err;
        m_resp_cnt  = cnt_a;
        if (sel == 2'd1) begin
            m_req_ready = ifb.req_ready;
            m_rsp_valid = ifb.rsp_valid;
            m_rsp_inst  = ifb.rsp_inst;
            m_rsp_err   = ifb.rsp_err;
            m_resp_cnt  = cnt_b;
        end else if (sel == 2'd2) begin
            m_req_ready = ifc.req_ready;
            m_rsp_valid = ifc.rsp_valid;
            m_rsp_inst  = ifc.rsp_inst;
            m_rsp_err   = ifc.rsp_err;
            m_resp_cnt  = cnt_c;
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [9:0] idx, input logic [31:0] data);
        @(negedge clk);
        ld_en   = 1'b1;
        ld_idx  = idx;
        ld_data = data;
        @(posedge clk);
        #1 ld_en = 1'b0;
    endtask

    // Presents one request; returns 1ns after the accepting edge.
    task automatic issue(input logic [31:0] a);
        @(negedge clk);
        chk("req_ready before accept", {31'd0, m_req_ready}, 32'd1);
        req_valid = 1'b1;
        req_addr  = a;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // lat = index of the first edge after acceptance at which rsp_valid is high.
    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!m_rsp_valid && lat < 40);
        if (!m_rsp_valid) chk("rsp_valid timeout", {31'd0, m_rsp_valid}, 32'd1);
    endtask

    task automatic fetch(input string tag, input logic [31:0] a, input logic [31:0] e_inst,
                         input logic e_err, input int e_lat);
        int lat;
        rsp_ready = 1'b1;
        issue(a);
        wait_valid(lat);
        chk({tag, " latency"}, 32'(lat), 32'(e_lat));
        chk({tag, " inst"}, m_rsp_inst, e_inst);
        chk({tag, " err"}, {31'd0, m_rsp_err}, {31'd0, e_err});
        @(posedge clk);
        #1;
        exp_cnt++;
    endtask

    initial begin
        int lat;
        n_cmp = 0; n_err = 0; exp_cnt = 0;
        sel = 2'd0; req_valid = 1'b0; req_addr = '0; flush = 1'b0; rsp_ready = 1'b0;
        ld_en = 1'b0; ld_idx = '0; ld_data = '0;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("reset rsp_valid", {31'd0, m_rsp_valid}, 32'd0);
        chk("reset req_ready", {31'd0, m_req_ready}, 32'd1);
        chk("reset rsp_inst", m_rsp_inst, 32'd0);
        chk("reset rsp_err", {31'd0, m_rsp_err}, 32'd0);
        chk("reset resp_cnt", {16'd0, m_resp_cnt}, 32'd0);

        preload(10'd0, 32'h0000_0413);
        preload(10'd1, 32'h0010_0093);
        preload(10'd3, 32'h1111_1111);
        preload(10'd1023, 32'hA5A5_A5A5);

        fetch("word0", 32'h8000_0000, 32'h0000_0413, 1'b0, 2);
        fetch("word1", 32'h8000_0004, 32'h0010_0093, 1'b0, 2);
        chk("resp_cnt after 2", {16'd0, m_resp_cnt}, 32'(exp_cnt));

        fetch("misaligned", 32'h8000_0002, 32'd0, 1'b1, 2);
        fetch("past end", 32'h8000_1000, 32'd0, 1'b1, 2);
        fetch("below base", 32'h7FFF_FFFC, 32'd0, 1'b1, 2);
        fetch("last word", 32'h8000_0FFC, 32'hA5A5_A5A5, 1'b0, 2);
        chk("resp_cnt after faults", {16'd0, m_resp_cnt}, 32'(exp_cnt));

        // Backpressure: response held for 5 cycles.
        rsp_ready = 1'b0;
        issue(32'h8000_0004);
        wait_valid(lat);
        for (int i = 0; i < 5; i++) begin
            chk("hold rsp_valid", {31'd0, m_rsp_valid}, 32'd1);
            chk("hold rsp_inst", m_rsp_inst, 32'h0010_0093);
            chk("hold req_ready", {31'd0, m_req_ready}, 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        exp_cnt++;
        @(negedge clk);
        chk("release rsp_valid", {31'd0, m_rsp_valid}, 32'd0);
        chk("release req_ready", {31'd0, m_req_ready}, 32'd1);
        chk("release resp_cnt", {16'd0, m_resp_cnt}, 32'(exp_cnt));

        // Flush one cycle after acceptance.
        issue(32'h8000_0000);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("flushed wait rsp_valid", {31'd0, m_rsp_valid}, 32'd0);
        end
        chk("flushed wait resp_cnt", {16'd0, m_resp_cnt}, 32'(exp_cnt));
        fetch("after flush", 32'h8000_0004, 32'h0010_0093, 1'b0, 2);

        // Flush together with rsp_ready in RESP: dropped.
        rsp_ready = 1'b1;
        issue(32'h8000_0004);
        wait_valid(lat);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("flush in RESP rsp_valid", {31'd0, m_rsp_valid}, 32'd0);
        chk("flush in RESP req_ready", {31'd0, m_req_ready}, 32'd1);
        chk("flush in RESP resp_cnt", {16'd0, m_resp_cnt}, 32'(exp_cnt));

        // Preload to word 3 on the same edge the fetch enters RESP: old data.
        rsp_ready = 1'b0;
        issue(32'h8000_000C);
        @(negedge clk);
        ld_en = 1'b1; ld_idx = 10'd3; ld_data = 32'hDEAD_BEEF;
        @(posedge clk);
        #1 ld_en = 1'b0;
        @(negedge clk);
        chk("rbw rsp_valid", {31'd0, m_rsp_valid}, 32'd1);
        chk("rbw old data", m_rsp_inst, 32'h1111_1111);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 exp_cnt++;
        fetch("refetch word3", 32'h8000_000C, 32'hDEAD_BEEF, 1'b0, 2);

        // Preload after the response is held does not change it.
        rsp_ready = 1'b0;
        issue(32'h8000_0000);
        wait_valid(lat);
        preload(10'd0, 32'h1234_5678);
        @(negedge clk);
        chk("held vs later preload", m_rsp_inst, 32'h0000_0413);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 exp_cnt++;
        fetch("word0 reloaded", 32'h8000_0000, 32'h1234_5678, 1'b0, 2);
        chk("resp_cnt before reset", {16'd0, m_resp_cnt}, 32'(exp_cnt));

        // Asynchronous reset mid-WAIT.
        issue(32'h8000_0000);
        #2 rstn = 1'b0;
        #1;
        chk("async rst rsp_valid", {31'd0, m_rsp_valid}, 32'd0);
        chk("async rst req_ready", {31'd0, m_req_ready}, 32'd1);
        chk("async rst resp_cnt", {16'd0, m_resp_cnt}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("lost fetch rsp_valid", {31'd0, m_rsp_valid}, 32'd0);
        end

        // Latency sweep.
        sel = 2'd1;
        fetch("L1 word0", 32'h8000_0000, 32'h1234_5678, 1'b0, 1);
        fetch("L1 misaligned", 32'h8000_0002, 32'd0, 1'b1, 1);
        sel = 2'd2;
        fetch("L15 word1", 32'h8000_0004, 32'h0010_0093, 1'b0, 15);
        chk("L15 resp_cnt", {16'd0, m_resp_cnt}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
